// File: rtl/num_cmp_seq_if.sv
// Handshake and operand/result bundle for the digit-serial magnitude comparator.
// The master drives a compare request; the slave (the comparator) returns status and result.
interface num_cmp_seq_if #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
);
  localparam int NDIG = (WIDTH + DIGIT - 1) / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);

  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             Y1;
  logic             Y2;
  logic             Y0;
  logic [CW-1:0]    cycles;

  modport master (
    output start, signed_mode, A, B,
    input  busy, done, Y1, Y2, Y0, cycles
  );

  modport slave (
    input  start, signed_mode, A, B,
    output busy, done, Y1, Y2, Y0, cycles
  );
endinterface

// File: rtl/num_cmp_seq.sv
// Digit-serial MSB-first magnitude comparator with early exit on the first differing digit.
// Signed compares flip the operand sign bits at capture and then reuse the unsigned datapath.
module num_cmp_seq #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  num_cmp_seq_if.slave  bus
);
  localparam int NDIG = (WIDTH + DIGIT - 1) / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);
  localparam int PW   = NDIG * DIGIT;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    a_q, a_d;
  logic [PW-1:0]    b_q, b_d;
  logic [CW-1:0]    dig_q, dig_d;
  logic             y0_q, y0_d;
  logic             y1_q, y1_d;
  logic             y2_q, y2_d;
  logic [CW-1:0]    cycles_q, cycles_d;

  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [DIGIT-1:0] a_top;
  logic [DIGIT-1:0] b_top;

  assign a_top = a_q[PW-1 -: DIGIT];
  assign b_top = b_q[PW-1 -: DIGIT];

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    dig_d    = dig_q;
    y0_d     = y0_q;
    y1_d     = y1_q;
    y2_d     = y2_q;
    cycles_d = cycles_q;

    // Inverting the sign bit maps two's-complement order onto unsigned order.
    a_in = bus.A;
    b_in = bus.B;
    a_in[WIDTH-1] = bus.A[WIDTH-1] ^ bus.signed_mode;
    b_in[WIDTH-1] = bus.B[WIDTH-1] ^ bus.signed_mode;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          state_d              = RUN;
          a_d                  = '0;
          b_d                  = '0;
          a_d[PW-1 -: WIDTH]   = a_in;
          b_d[PW-1 -: WIDTH]   = b_in;
          dig_d                = '0;
        end
      end
      RUN: begin
        dig_d = dig_q + 1'b1;
        if (a_top != b_top) begin
          state_d  = DONE;
          y1_d     = (a_top > b_top);
          y2_d     = (a_top < b_top);
          y0_d     = 1'b0;
          cycles_d = dig_q + 1'b1;
        end else if (dig_q == CW'(NDIG - 1)) begin
          state_d  = DONE;
          y1_d     = 1'b0;
          y2_d     = 1'b0;
          y0_d     = 1'b1;
          cycles_d = CW'(NDIG);
        end else begin
          a_d = a_q << DIGIT;
          b_d = b_q << DIGIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      dig_q    <= '0;
      y0_q     <= 1'b0;
      y1_q     <= 1'b0;
      y2_q     <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      dig_q    <= dig_d;
      y0_q     <= y0_d;
      y1_q     <= y1_d;
      y2_q     <= y2_d;
      cycles_q <= cycles_d;
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.Y0     = y0_q;
  assign bus.Y1     = y1_q;
  assign bus.Y2     = y2_q;
  assign bus.cycles = cycles_q;

endmodule

// File: tb/tb_num_cmp_seq.sv
// Directed bench for num_cmp_seq: 8/2 main config, 6/4 padded config and an exhaustive 4/1 sweep.
// Results are packed as {Y1,Y2,Y0,cycles[2:0]} for compact comparison.
module tb_num_cmp_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   asserts  = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  num_cmp_seq_if #(.WIDTH(8), .DIGIT(2)) bus8 ();
  num_cmp_seq_if #(.WIDTH(6), .DIGIT(4)) bus6 ();
  num_cmp_seq_if #(.WIDTH(4), .DIGIT(1)) bus4 ();

  num_cmp_seq #(.WIDTH(8), .DIGIT(2)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  num_cmp_seq #(.WIDTH(6), .DIGIT(4)) dut6 (.clk(clk), .rst(rst), .bus(bus6));
  num_cmp_seq #(.WIDTH(4), .DIGIT(1)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int which, input logic st, input logic [7:0] a, input logic [7:0] b,
                       input logic sm);
    case (which)
      0: begin bus8.start = st; bus8.A = a;      bus8.B = b;      bus8.signed_mode = sm; end
      1: begin bus6.start = st; bus6.A = a[5:0]; bus6.B = b[5:0]; bus6.signed_mode = sm; end
      default: begin bus4.start = st; bus4.A = a[3:0]; bus4.B = b[3:0]; bus4.signed_mode = sm; end
    endcase
  endtask

  function automatic logic get_done(input int which);
    case (which)
      0:       return bus8.done;
      1:       return bus6.done;
      default: return bus4.done;
    endcase
  endfunction

  function automatic logic get_busy(input int which);
    case (which)
      0:       return bus8.busy;
      1:       return bus6.busy;
      default: return bus4.busy;
    endcase
  endfunction

  function automatic logic [5:0] get_res(input int which);
    case (which)
      0:       return {bus8.Y1, bus8.Y2, bus8.Y0, 3'(bus8.cycles)};
      1:       return {bus6.Y1, bus6.Y2, bus6.Y0, 3'(bus6.cycles)};
      default: return {bus4.Y1, bus4.Y2, bus4.Y0, 3'(bus4.cycles)};
    endcase
  endfunction

  // Issues one compare and waits (bounded) for done; n = edges from start-accept to done.
  task automatic run_cmp(input int which, input logic [7:0] a, input logic [7:0] b, input logic sm,
                         output int n, output int bc);
    drive(which, 1'b1, a, b, sm);
    step();
    drive(which, 1'b0, a, b, sm);
    n  = 0;
    bc = 0;
    while (!get_done(which) && n < 20) begin
      if (get_busy(which)) bc++;
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    logic [5:0] r;
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(2, 1'b0, 8'h00, 8'h00, 1'b0);
    rst = 1'b1;
    step();
    step();
    asserts++;
    if ({bus8.busy, bus8.done} !== 2'b00) begin
      failures++; $display("FAIL reset_status8: got %b required 00", {bus8.busy, bus8.done});
    end
    r = get_res(0);
    asserts++;
    if (r !== 6'b000_000) begin failures++; $display("FAIL reset_result8: got %b required 000000", r); end
    r = get_res(1);
    asserts++;
    if (r !== 6'b000_000) begin failures++; $display("FAIL reset_result6: got %b required 000000", r); end
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int n, bc;
    logic [5:0] r;
    run_cmp(0, 8'hF0, 8'h0F, 1'b0, n, bc);
    r = get_res(0);
    asserts++;
    if (r !== 6'b100_001) begin failures++; $display("FAIL f0_vs_0f_result: got %b required 100001", r); end
    asserts++;
    if (n !== 1) begin failures++; $display("FAIL f0_vs_0f_latency: got %0d required 1", n); end
    step();
    asserts++;
    if ({bus8.busy, bus8.done} !== 2'b00) begin
      failures++; $display("FAIL f0_vs_0f_done_pulse: got %b required 00", {bus8.busy, bus8.done});
    end
  endtask

  task automatic test_long();
    int n, bc;
    logic [5:0] r;
    run_cmp(0, 8'h13, 8'h12, 1'b0, n, bc);
    r = get_res(0);
    asserts++;
    if (r !== 6'b100_100) begin failures++; $display("FAIL 13_vs_12_result: got %b required 100100", r); end
    asserts++;
    if (n !== 4) begin failures++; $display("FAIL 13_vs_12_latency: got %0d required 4", n); end
    run_cmp(0, 8'h5A, 8'h5A, 1'b0, n, bc);
    r = get_res(0);
    asserts++;
    if (r !== 6'b001_100) begin failures++; $display("FAIL 5a_eq_result: got %b required 001100", r); end
    asserts++;
    if (bc !== 4) begin failures++; $display("FAIL 5a_eq_busy_cycles: got %0d required 4", bc); end
    run_cmp(0, 8'h34, 8'h38, 1'b0, n, bc);
    r = get_res(0);
    asserts++;
    if (r !== 6'b010_011) begin failures++; $display("FAIL 34_vs_38_result: got %b required 010011", r); end
    asserts++;
    if (n !== 3) begin failures++; $display("FAIL 34_vs_38_latency: got %0d required 3", n); end
  endtask

  task automatic test_signed();
    int n, bc;
    logic [5:0] r;
    run_cmp(0, 8'h80, 8'h01, 1'b1, n, bc);
    r = get_res(0);
    asserts++;
    if (r !== 6'b010_001) begin failures++; $display("FAIL s80_vs_01_result: got %b required 010001", r); end
    run_cmp(0, 8'h80, 8'h01, 1'b0, n, bc);
    r = get_res(0);
    asserts++;
    if (r !== 6'b100_001) begin failures++; $display("FAIL u80_vs_01_result: got %b required 100001", r); end
    run_cmp(0, 8'hFF, 8'hFE, 1'b1, n, bc);
    r = get_res(0);
    asserts++;
    if (r !== 6'b100_100) begin failures++; $display("FAIL sff_vs_fe_result: got %b required 100100", r); end
    run_cmp(0, 8'h7F, 8'h80, 1'b1, n, bc);
    r = get_res(0);
    asserts++;
    if (r !== 6'b100_001) begin failures++; $display("FAIL s7f_vs_80_result: got %b required 100001", r); end
  endtask

  task automatic test_ignore_start();
    int n;
    logic [5:0] r;
    drive(0, 1'b1, 8'h13, 8'h12, 1'b0);
    step();
    drive(0, 1'b0, 8'h13, 8'h12, 1'b0);
    step();
    drive(0, 1'b1, 8'h00, 8'hFF, 1'b1);
    step();
    drive(0, 1'b0, 8'h00, 8'hFF, 1'b1);
    n = 2;
    while (!bus8.done && n < 20) begin
      step();
      n++;
    end
    r = get_res(0);
    asserts++;
    if (r !== 6'b100_100) begin failures++; $display("FAIL ignore_start_result: got %b required 100100", r); end
    asserts++;
    if (n !== 4) begin failures++; $display("FAIL ignore_start_latency: got %0d required 4", n); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [5:0] r;
    drive(0, 1'b1, 8'hF0, 8'h0F, 1'b0);
    step();
    step();
    r = get_res(0);
    asserts++;
    if ({bus8.done, r} !== {1'b1, 6'b100_001}) begin
      failures++; $display("FAIL b2b_first: got done=%b res=%b required done=1 res=100001", bus8.done, r);
    end
    drive(0, 1'b1, 8'h01, 8'h02, 1'b0);
    step();
    asserts++;
    if ({bus8.busy, bus8.done} !== 2'b10) begin
      failures++; $display("FAIL b2b_no_idle: got %b required 10", {bus8.busy, bus8.done});
    end
    drive(0, 1'b0, 8'h01, 8'h02, 1'b0);
    n = 0;
    while (!bus8.done && n < 20) begin
      step();
      n++;
    end
    r = get_res(0);
    asserts++;
    if (r !== 6'b010_100) begin failures++; $display("FAIL b2b_second_result: got %b required 010100", r); end
    asserts++;
    if (n !== 4) begin failures++; $display("FAIL b2b_second_latency: got %0d required 4", n); end
  endtask

  task automatic test_reset_mid_run();
    int n, bc;
    logic [5:0] r;
    drive(0, 1'b1, 8'h13, 8'h12, 1'b0);
    step();
    drive(0, 1'b0, 8'h13, 8'h12, 1'b0);
    step();
    rst = 1'b1;
    step();
    r = get_res(0);
    asserts++;
    if ({bus8.busy, bus8.done, r} !== 8'h00) begin
      failures++;
      $display("FAIL midrun_reset: got busy=%b done=%b res=%b required all 0", bus8.busy, bus8.done, r);
    end
    rst = 1'b0;
    run_cmp(0, 8'h5A, 8'h5B, 1'b0, n, bc);
    r = get_res(0);
    asserts++;
    if (r !== 6'b010_100) begin failures++; $display("FAIL after_reset_result: got %b required 010100", r); end
    asserts++;
    if (bc !== 4) begin failures++; $display("FAIL after_reset_busy_cycles: got %0d required 4", bc); end
  endtask

  task automatic test_padding();
    int n, bc;
    logic [5:0] r;
    run_cmp(1, 8'h21, 8'h22, 1'b0, n, bc);
    r = get_res(1);
    asserts++;
    if (r !== 6'b010_010) begin failures++; $display("FAIL pad_21_vs_22: got %b required 010010", r); end
    run_cmp(1, 8'h3F, 8'h3F, 1'b0, n, bc);
    r = get_res(1);
    asserts++;
    if (r !== 6'b001_010) begin failures++; $display("FAIL pad_3f_eq: got %b required 001010", r); end
    run_cmp(1, 8'h20, 8'h1F, 1'b1, n, bc);
    r = get_res(1);
    asserts++;
    if (r !== 6'b010_001) begin failures++; $display("FAIL pad_s20_vs_1f: got %b required 010001", r); end
  endtask

  task automatic test_exhaustive();
    int n, bc, av, bv, ecyc;
    logic found;
    logic [5:0] r, e;
    for (int sm = 0; sm < 2; sm++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          av = (sm == 1 && a >= 8) ? a - 16 : a;
          bv = (sm == 1 && b >= 8) ? b - 16 : b;
          ecyc  = 4;
          found = 1'b0;
          for (int i = 3; i >= 0; i--) begin
            if (!found && (((a >> i) & 1) != ((b >> i) & 1))) begin
              ecyc  = 4 - i;
              found = 1'b1;
            end
          end
          e = {(av > bv), (av < bv), (av == bv), 3'(ecyc)};
          run_cmp(2, 8'(a), 8'(b), 1'(sm), n, bc);
          r = get_res(2);
          asserts++;
          if (r !== e) begin
            failures++; $display("FAIL sweep sm=%0d a=%0h b=%0h: got %b required %b", sm, a, b, r, e);
          end
          asserts++;
          if ($countones(r[5:3]) != 1) begin
            failures++; $display("FAIL sweep_onehot sm=%0d a=%0h b=%0h: got %b required one-hot", sm, a, b, r[5:3]);
          end
          asserts++;
          if (n !== ecyc) begin
            failures++; $display("FAIL sweep_latency sm=%0d a=%0h b=%0h: got %0d required %0d", sm, a, b, n, ecyc);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_long();
    test_signed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_padding();
    test_exhaustive();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end
endmodule

// File: doc/num_cmp_seq.md
# num_cmp_seq

Parametrised, sequential magnitude comparator: successor to the 4-bit combinational `num_in` comparator. It compares two WIDTH-bit operands digit-serially, MSB-first, DIGIT bits per cycle, with early termination on the first differing digit. It supports unsigned and two's-complement modes and uses a start/busy/done handshake. It sits in the num compare datapath wherever wide operands make a single-cycle compare too slow or too large.

## Interface
- `WIDTH`, default 16: operand width in bits, ≥ 1.
- `DIGIT`, default 4: bits compared per cycle, 1 ≤ DIGIT ≤ WIDTH.
- `NDIG` (localparam): ceil(WIDTH/DIGIT), the number of digits.
- `CW` (localparam): $clog2(NDIG+1), the width of `cycles`.
- `clk  in  1`: single clock; all logic on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `start  in  1`: request a compare; accepted only when `busy`=0.
- `signed_mode  in  1`: 1 selects two's-complement compare, 0 selects unsigned; sampled with `start`.
- `A  in  WIDTH`: operand A; sampled with `start`.
- `B  in  WIDTH`: operand B; sampled with `start`.
- `busy  out  1`: high while a compare is in progress.
- `done  out  1`: one-cycle pulse when the result is updated.
- `Y1  out  1`: A > B.
- `Y2  out  1`: A < B.
- `Y0  out  1`: A == B.
- `cycles  out  CW`: number of digit cycles used by the last compare, 1..NDIG.

## Operation
- Three-state FSM with states IDLE, RUN and DONE.
  - IDLE: `busy`=0, `done`=0.
  - RUN: `busy`=1.
  - DONE: `busy`=0, `done`=1, lasting exactly one cycle.
- Start acceptance: `start`=1 in IDLE or DONE captures the operands and moves to RUN. `start` while in RUN is ignored; the operands do not change.
- Operand capture:
  - Operands are loaded into internal shift registers, each left-aligned to NDIG*DIGIT bits.
  - LSB padding is zeros, which is neutral for the result.
  - If `signed_mode`=1, bit WIDTH-1 of both operands is inverted at capture. The compare is then unsigned on the transformed values.
- Each RUN cycle compares the top DIGIT bits of the two shift registers as unsigned values, and increments the digit counter.
  - Digits differ: latch Y1/Y2 (exactly one high, Y0=0), latch `cycles`=digit index+1, go to DONE.
  - Digits equal and not the last digit: shift both registers left by DIGIT, stay in RUN.
  - Digits equal and last digit (index NDIG-1): latch Y0=1, Y1=Y2=0, `cycles`=NDIG, go to DONE.
- DONE returns to IDLE, or to RUN if `start`=1 in that cycle (back-to-back compares).
- Result outputs:
  - Y0/Y1/Y2/`cycles` are registered.
  - They hold the previous result throughout RUN and change only on the edge entering DONE.
  - After the first completion, exactly one of Y0/Y1/Y2 is high.

## Timing
- Reset (`rst`=1 at an edge): state goes to IDLE. `busy`=0, `done`=0, Y0=Y1=Y2=0, `cycles`=0, and the shift registers and digit counter are cleared. `rst` overrides `start`.
- Reset mid-RUN aborts the compare with no `done` pulse. `start` is accepted on the first edge after `rst` deasserts.
- Latency:
  - `start` sampled at edge t0 puts the FSM in RUN after t0.
  - A compare resolved at digit i (0-based) puts the FSM in DONE after edge t0+i+1.
  - `done` is high during the cycle following edge t0+i+1.
  - Minimum latency 1 cycle, maximum NDIG cycles.
- Throughput: one compare per (cycles+1) clock cycles when `start` is held high.
- DIGIT=WIDTH gives NDIG=1: every compare takes 1 RUN cycle, and `cycles` is always 1.

## Test plan
- WIDTH=8, DIGIT=2, unsigned, A=0xF0, B=0x0F: Y1=1, Y2=0, Y0=0, `cycles`=1; `done` is high exactly one cycle, one cycle after `start`.
- WIDTH=8, DIGIT=2, A=0x13, B=0x12: Y1=1, `cycles`=4. A=B=0x5A: Y0=1, `cycles`=4, `busy` high for 4 cycles.
- WIDTH=8, DIGIT=2, A=0x80, B=0x01:
  - `signed_mode`=1 gives Y2=1 (−128 < 1).
  - `signed_mode`=0 gives Y1=1 (128 > 1).
- `start` pulsed mid-RUN with new operands: ignored, result matches the original operands. `start` held high through DONE: the next compare begins immediately, with no IDLE cycle.
- `rst` asserted during the 2nd RUN cycle:
  - On the next edge, all outputs are 0 and no `done` pulse occurs.
  - A fresh `start` after `rst` deasserts completes correctly.
- WIDTH=4, DIGIT=1, exhaustive sweep of all 256 (A,B) pairs in both modes, against a behavioural reference model: exactly one of Y0/Y1/Y2 is high, `cycles` equals the index of the first differing bit + 1 (4 if equal), and there are zero mismatches.
